// File: rtl/player_link_ctl.sv
// player_link_ctl: shares player position/level between two boards
// as a framed, checksummed 5-byte packet over a byte-wide UART.

module player_link_ctl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         BYTE_TIMEOUT = 20000,
    parameter int         LINK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [10:0] x_local,
    input  logic [10:0] y_local,
    input  logic [1:0]  level_local,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [10:0] x_remote,
    output logic [10:0] y_remote,
    output logic [1:0]  level_remote,
    output logic        remote_valid,
    output logic        chk_err
);

    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam int LW = $clog2(LINK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 1);
    localparam logic [LW-1:0] LINK_MAX = LW'(LINK_TIMEOUT);
    localparam logic [LW-1:0] LINK_PRE = LW'(LINK_TIMEOUT - 1);

    typedef enum logic {T_IDLE, T_SEND} tx_state_t;
    typedef enum logic [1:0] {R_SYNC, R_DATA, R_CHK} rx_state_t;

    tx_state_t   t_state, t_next;
    logic [2:0]  idx, idx_next;
    logic        pending, pending_next;
    logic        load;
    logic [7:0]  b1, b2, b3, b4;
    logic [7:0]  n1, n2, n3;

    rx_state_t   r_state, r_next;
    logic [1:0]  r_cnt;
    logic [7:0]  sh1, sh2, sh3;
    logic [TW-1:0] timer;
    logic        good, bad;
    logic [LW-1:0] link_cnt;

    // Packet bytes built from the live local state, captured on load.
    always_comb begin
        n1 = x_local[7:0];
        n2 = {y_local[4:0], x_local[10:8]};
        n3 = {level_local, y_local[10:5]};
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_state <= T_IDLE;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            t_state <= t_next;
            idx     <= idx_next;
            pending <= pending_next;
        end
    end

    // TX next state: a tick during a packet queues at most one more.
    always_comb begin
        t_next       = t_state;
        idx_next     = idx;
        pending_next = pending;
        load         = 1'b0;
        unique case (t_state)
            T_IDLE: begin
                if (frame_tick) begin
                    load     = 1'b1;
                    t_next   = T_SEND;
                    idx_next = '0;
                end
            end
            T_SEND: begin
                if (frame_tick)
                    pending_next = 1'b1;
                if (tx_ready) begin
                    if (idx == 3'd4) begin
                        if (pending || frame_tick) begin
                            load         = 1'b1;
                            idx_next     = '0;
                            pending_next = 1'b0;
                        end else begin
                            t_next = T_IDLE;
                        end
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            default: t_next = T_IDLE;
        endcase
    end

    // Snapshot held for the whole packet so stalls see stable bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b1 <= '0;
            b2 <= '0;
            b3 <= '0;
            b4 <= '0;
        end else if (load) begin
            b1 <= n1;
            b2 <= n2;
            b3 <= n3;
            b4 <= n1 ^ n2 ^ n3;
        end
    end

    // Byte select; idle drives zero.
    always_comb begin
        tx_valid = (t_state == T_SEND);
        tx_data  = '0;
        if (t_state == T_SEND) begin
            unique case (idx)
                3'd0:    tx_data = SYNC_BYTE;
                3'd1:    tx_data = b1;
                3'd2:    tx_data = b2;
                3'd3:    tx_data = b3;
                default: tx_data = b4;
            endcase
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= R_SYNC;
        else
            r_state <= r_next;
    end

    // RX next state: hunt sync, gather three bytes, verify checksum.
    always_comb begin
        r_next = r_state;
        good   = 1'b0;
        bad    = 1'b0;
        unique case (r_state)
            R_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE)
                    r_next = R_DATA;
            end
            R_DATA: begin
                if (rx_valid) begin
                    if (r_cnt == 2'd2)
                        r_next = R_CHK;
                end else if (timer == TMO_LAST) begin
                    r_next = R_SYNC;
                end
            end
            R_CHK: begin
                if (rx_valid) begin
                    r_next = R_SYNC;
                    if (rx_data == (sh1 ^ sh2 ^ sh3))
                        good = 1'b1;
                    else
                        bad = 1'b1;
                end else if (timer == TMO_LAST) begin
                    r_next = R_SYNC;
                end
            end
            default: r_next = R_SYNC;
        endcase
    end

    // Shadow buffer and inter-byte timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            sh1   <= '0;
            sh2   <= '0;
            sh3   <= '0;
            timer <= '0;
        end else begin
            if (r_state == R_SYNC || rx_valid)
                timer <= '0;
            else
                timer <= timer + TW'(1);
            if (r_state == R_SYNC) begin
                r_cnt <= '0;
            end else if (r_state == R_DATA && rx_valid) begin
                r_cnt <= r_cnt + 2'd1;
                unique case (r_cnt)
                    2'd0:    sh1 <= rx_data;
                    2'd1:    sh2 <= rx_data;
                    default: sh3 <= rx_data;
                endcase
            end
        end
    end

    // Remote registers update atomically on a good packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_remote     <= '0;
            y_remote     <= '0;
            level_remote <= '0;
            chk_err      <= 1'b0;
        end else begin
            chk_err <= bad;
            if (good) begin
                x_remote     <= {sh2[2:0], sh1};
                y_remote     <= {sh3[5:0], sh2[7:3]};
                level_remote <= sh3[7:6];
            end
        end
    end

    // Link watchdog; a good packet beats a simultaneous tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link_cnt     <= '0;
            remote_valid <= 1'b0;
        end else if (good) begin
            link_cnt     <= '0;
            remote_valid <= 1'b1;
        end else if (frame_tick && link_cnt != LINK_MAX) begin
            link_cnt <= link_cnt + LW'(1);
            if (link_cnt == LINK_PRE)
                remote_valid <= 1'b0;
        end
    end

endmodule
